// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
//   Shared definitions for the instruction-fetch slice of the MIPS pipeline:
//   the 32-bit word type, default reset and exception-vector addresses, the
//   AdEL exception code, and the 3-bit next-PC-source encoding. The hazard
//   trace monitor decodes the same encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEF   = 32'h0000_3000;
  localparam word_t EXC_VECTOR_DEF = 32'h0000_4180;
  localparam word_t IM_BASE_DEF    = 32'h0000_3000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Source of the PC value loaded at the next rising edge.
  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,  // pc + 4
    NPC_BR   = 3'd1,  // resolved branch/jump target
    NPC_PEND = 3'd2,  // redirect held back by an earlier stall
    NPC_EXC  = 3'd3,  // exception / interrupt vector
    NPC_ERET = 3'd4,  // return to EPC
    NPC_HOLD = 3'd5   // stalled, PC unchanged
  } npc_src_e;

  // Sequential successor; wraps modulo 2^32.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_npc_sel.sv
// ----------------------------------------------------------------------------
// if_npc_sel
//   Combinational next-PC priority mux for the fetch stage.
//   Priority, highest first: exception, eret, stall (hold), taken branch,
//   pending redirect, sequential.
//   Ports:
//     pc, epc, branch_target, pend_target  in  32  candidate addresses
//     exc_req, eret_req, stall             in  1   redirect / hold requests
//     branch_taken, pend_valid             in  1   redirect qualifiers
//     next_pc                              out 32  PC to load at the edge
//     npc_src                              out 3   npc_src_e code of choice
// ----------------------------------------------------------------------------
module if_npc_sel
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic [31:0] next_pc,
  output logic [2:0]  npc_src
);

  always_comb begin
    next_pc = pc_plus4(pc);
    npc_src = NPC_SEQ;
    // Exception and eret redirect even through a stall: the pipeline is being
    // flushed, so holding the PC would fetch from the wrong context.
    if (exc_req) begin
      next_pc = EXC_VECTOR;
      npc_src = NPC_EXC;
    end else if (eret_req) begin
      next_pc = epc;
      npc_src = NPC_ERET;
    end else if (stall) begin
      next_pc = pc;
      npc_src = NPC_HOLD;
    end else if (branch_taken) begin
      next_pc = branch_target;
      npc_src = NPC_BR;
    end else if (pend_valid) begin
      next_pc = pend_target;
      npc_src = NPC_PEND;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC and the
//   one-entry pending-redirect latch, reads the combinational instruction
//   memory and produces the IF/ID payload.
//   Optional feature: define IF_ADDR_CHECK_EN to flag AdEL for misaligned or
//   out-of-memory PCs; otherwise out-of-range PCs simply wrap in imem.
//   Ports:
//     clk, reset       in  1      rising-edge clock, sync active-high reset
//     stall            in  1      hold PC (shared with IF/ID enable)
//     branch_taken     in  1      D-stage branch/jump resolved taken
//     branch_target    in  32     its target
//     is_branch_D      in  1      instruction in D is a branch/jump
//     exc_req          in  1      CP0 takes an exception this cycle
//     eret_req, epc    in  1/32   eret committing, return address
//     imem_addr        out IM_AW  word index into instruction memory
//     imem_rdata       in  32     instruction memory read data
//     InstF            out 32     fetched instruction (0 on fault)
//     PCF, PC4F        out 32     current PC and PC+4
//     ExcBDF           out 1      fetched instruction is a delay slot
//     ExcOccurF        out 1      fetch exception present
//     ExcCodeF         out 5      exception code
// ----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
  parameter int          IM_WORDS   = 4096,
  parameter int          IM_AW      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             is_branch_D,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      InstF,
  output logic [31:0]      PCF,
  output logic [31:0]      PC4F,
  output logic             ExcBDF,
  output logic             ExcOccurF,
  output logic [4:0]       ExcCodeF
);

  // One past the last imem byte, kept at 33 bits so a memory ending at 4 GiB
  // does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [31:0] next_pc;
  logic [2:0]  npc_src;

  logic [31:0] im_off;
  logic        addr_bad;
  logic        fault;

  if_npc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_sel (
    .pc            (pc_q),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pend_valid    (pend_valid_q),
    .pend_target   (pend_target_q),
    .next_pc       (next_pc),
    .npc_src       (npc_src)
  );

  // Next-state for PC and the pending-redirect latch.
  always_comb begin
    pc_d          = next_pc;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    case (npc_src)
      NPC_EXC, NPC_ERET, NPC_BR, NPC_PEND: begin
        pend_valid_d = 1'b0;
      end
      NPC_HOLD: begin
        // A branch resolved while IF is frozen must not be lost; the latch
        // keeps only the most recent one.
        if (branch_taken) begin
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target;
        end
      end
      default: begin
      end
    endcase
    if (reset) begin
      pc_d          = RESET_PC;
      pend_valid_d  = 1'b0;
      pend_target_d = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    pc_q          <= pc_d;
    pend_valid_q  <= pend_valid_d;
    pend_target_q <= pend_target_d;
  end

  // ---- fetch / IF-ID payload ----
  assign im_off    = pc_q - IM_BASE;
  assign imem_addr = im_off[IM_AW+1:2];

  assign addr_bad = (pc_q[1:0] != 2'b00) ||
                    (pc_q < IM_BASE) ||
                    ({1'b0, pc_q} >= IM_END);

`ifdef IF_ADDR_CHECK_EN
  assign fault = addr_bad;
`else
  assign fault = 1'b0;
`endif

  // Offset bits outside the word index are intentionally dropped (imem wraps);
  // addr_bad only drives fault when the address check is built in.
  logic unused_ok;
  assign unused_ok = &{1'b0, im_off[31:IM_AW+2], im_off[1:0], addr_bad};

  assign PCF       = pc_q;
  assign PC4F      = pc_plus4(pc_q);
  assign ExcBDF    = is_branch_D & ~reset;
  assign InstF     = fault ? 32'h0000_0000 : imem_rdata;
  assign ExcOccurF = fault;
  assign ExcCodeF  = fault ? EXC_ADEL : EXC_NONE;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

`ifdef IF_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        is_branch_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] InstF;
  logic [31:0] PCF;
  logic [31:0] PC4F;
  logic        ExcBDF;
  logic        ExcOccurF;
  logic [4:0]  ExcCodeF;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] pcf;
    logic [31:0] pc4f;
    logic        bd;
    logic        occ;
    logic [4:0]  code;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  // Instruction memory model: each word holds a tag plus its own index.
  assign imem_rdata = {20'hA5A5A, imem_addr};

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .is_branch_D   (is_branch_D),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .InstF         (InstF),
    .PCF           (PCF),
    .PC4F          (PC4F),
    .ExcBDF        (ExcBDF),
    .ExcOccurF     (ExcOccurF),
    .ExcCodeF      (ExcCodeF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, req);
    end
  endtask

  // Monitor: the fetch stage presents a payload every cycle; compare whenever
  // an expectation has been queued for it.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "PCF",       PCF,              e.pcf);
      chk(e.nm, "PC4F",      PC4F,             e.pc4f);
      chk(e.nm, "ExcBDF",    {31'd0, ExcBDF},  {31'd0, e.bd});
      chk(e.nm, "ExcOccurF", {31'd0, ExcOccurF}, {31'd0, e.occ});
      chk(e.nm, "ExcCodeF",  {27'd0, ExcCodeF},  {27'd0, e.code});
      chk(e.nm, "InstF",     InstF,            e.inst);
    end
  end

  // One cycle: apply inputs (they act at the next edge) and queue the
  // outputs expected during this cycle. flt marks PCs that are AdEL when the
  // address check is built in.
  task automatic cyc(input logic rst_i, input logic st, input logic br,
                     input logic [31:0] tgt, input logic isb, input logic exc,
                     input logic eret, input logic [31:0] epc_i,
                     input string nm, input logic [31:0] e_pcf,
                     input logic [31:0] e_pc4f, input logic e_bd,
                     input logic [31:0] e_inst, input logic flt);
    exp_t e;
    reset         = rst_i;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    is_branch_D   = isb;
    exc_req       = exc;
    eret_req      = eret;
    epc           = epc_i;
    e.nm   = nm;
    e.pcf  = e_pcf;
    e.pc4f = e_pc4f;
    e.bd   = e_bd;
    e.occ  = CHK & flt;
    e.code = (CHK & flt) ? 5'd4 : 5'd0;
    e.inst = (CHK & flt) ? 32'h0 : e_inst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    is_branch_D = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    @(posedge clk);
    #1;
    //   rst st br target        isb exc ert epc           name     PCF           PC4F          bd  inst          flt
    cyc(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        "rst",    32'h0000_3000, 32'h0000_3004, 0, 32'hA5A5A000, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "run0",   32'h0000_3000, 32'h0000_3004, 0, 32'hA5A5A000, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "run1",   32'h0000_3004, 32'h0000_3008, 0, 32'hA5A5A001, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "run2",   32'h0000_3008, 32'h0000_300C, 0, 32'hA5A5A002, 0);
    cyc(0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        "bd",     32'h0000_300C, 32'h0000_3010, 1, 32'hA5A5A003, 0);
    cyc(0, 0, 1, 32'h3400,     0, 0, 0, 32'h0,        "br",     32'h0000_3010, 32'h0000_3014, 0, 32'hA5A5A004, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "brtgt",  32'h0000_3400, 32'h0000_3404, 0, 32'hA5A5A100, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 1, 32'h3010,     "eret1",  32'h0000_3404, 32'h0000_3408, 0, 32'hA5A5A101, 0);
    cyc(0, 1, 1, 32'h3400,     0, 0, 0, 32'h0,        "stl0",   32'h0000_3010, 32'h0000_3014, 0, 32'hA5A5A004, 0);
    cyc(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        "stl1",   32'h0000_3010, 32'h0000_3014, 0, 32'hA5A5A004, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "stl2",   32'h0000_3010, 32'h0000_3014, 0, 32'hA5A5A004, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "pend",   32'h0000_3400, 32'h0000_3404, 0, 32'hA5A5A100, 0);
    cyc(0, 1, 1, 32'h3500,     0, 0, 0, 32'h0,        "lw0",    32'h0000_3404, 32'h0000_3408, 0, 32'hA5A5A101, 0);
    cyc(0, 1, 1, 32'h3600,     0, 0, 0, 32'h0,        "lw1",    32'h0000_3404, 32'h0000_3408, 0, 32'hA5A5A101, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "lw2",    32'h0000_3404, 32'h0000_3408, 0, 32'hA5A5A101, 0);
    cyc(0, 1, 1, 32'h3700,     0, 0, 0, 32'h0,        "lwtgt",  32'h0000_3600, 32'h0000_3604, 0, 32'hA5A5A180, 0);
    cyc(0, 1, 0, 32'h0,        0, 1, 1, 32'h3010,     "exc",    32'h0000_3600, 32'h0000_3604, 0, 32'hA5A5A180, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "vec",    32'h0000_4180, 32'h0000_4184, 0, 32'hA5A5A460, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 1, 32'h3002,     "nopend", 32'h0000_4184, 32'h0000_4188, 0, 32'hA5A5A461, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "mis0",   32'h0000_3002, 32'h0000_3006, 0, 32'hA5A5A000, 1);
    cyc(0, 0, 0, 32'h0,        0, 0, 1, 32'h2FFC,     "mis1",   32'h0000_3006, 32'h0000_300A, 0, 32'hA5A5A001, 1);
    cyc(0, 0, 0, 32'h0,        0, 0, 1, 32'h6FFC,     "below",  32'h0000_2FFC, 32'h0000_3000, 0, 32'hA5A5AFFF, 1);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "last",   32'h0000_6FFC, 32'h0000_7000, 0, 32'hA5A5AFFF, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 1, 32'hFFFF_FFFC, "end",   32'h0000_7000, 32'h0000_7004, 0, 32'hA5A5A000, 1);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "top",    32'hFFFF_FFFC, 32'h0000_0000, 0, 32'hA5A5A3FF, 1);
    cyc(0, 1, 1, 32'h3800,     0, 0, 0, 32'h0,        "wrap",   32'h0000_0000, 32'h0000_0004, 0, 32'hA5A5A400, 1);
    cyc(1, 1, 0, 32'h0,        1, 0, 0, 32'h0,        "rststl", 32'h0000_0000, 32'h0000_0004, 0, 32'hA5A5A400, 1);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "rst2",   32'h0000_3000, 32'h0000_3004, 0, 32'hA5A5A000, 0);
    cyc(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        "nopnd2", 32'h0000_3004, 32'h0000_3008, 0, 32'hA5A5A001, 0);
    @(negedge clk);
    #1;
    chk("drain", "queued", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
